// File: rtl/adder_n.sv
`default_nettype none
// ============================================================================
//  Module   : adder_n
//  Purpose  : Parameterised N-bit ripple-carry adder built from a chain of
//             full-adder cells. Sum, carry-out and signed overflow are
//             registered behind a valid strobe, giving one cycle of latency.
//             The registered Cout can feed the Cin of a higher slice.
//  Revision : 1.0 - initial release
// ============================================================================
module adder_n #(
    parameter int N = 4                   // operand/sum width, 1..64
) (
    input  logic         clk,
    input  logic         rst,
    output logic [N-1:0] SUM,
    output logic         Cout,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    input  logic         in_valid,
    output logic         out_valid,
    output logic         ovf
);

    // Carry chain: w_c[0] is the external carry-in, w_c[N] the carry-out.
    logic [N:0]   w_c;
    logic [N-1:0] w_s;
    logic         w_ovf;

    assign w_c[0] = Cin;

    // One full-adder cell per bit; the ripple path is kept explicit.
    generate
        for (genvar i = 0; i < N; i++) begin : g_fa
            assign w_s[i]   = A[i] ^ B[i] ^ w_c[i];
            assign w_c[i+1] = (A[i] & B[i]) | (w_c[i] & (A[i] ^ B[i]));
        end
    endgenerate

    // Signed overflow: carry into the MSB differs from carry out of it.
    // For N=1 the carry into the MSB is Cin itself (w_c[0]).
    assign w_ovf = w_c[N] ^ w_c[N-1];

    // Capture a new result when operands are valid; otherwise hold the
    // previous result so idle-cycle inputs cannot disturb it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            SUM       <= '0;
            Cout      <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                SUM  <= w_s;
                Cout <= w_c[N];
                ovf  <= w_ovf;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adder_n.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adder_n
//  Purpose  : Self-checking bench for adder_n: a 4-bit slice, a 13-bit slice
//             and a two-slice 8-bit cascade, compared against an arithmetic
//             reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_adder_n;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int errors = 0;
    int checks = 0;

    // ---------------- 4-bit slice ----------------
    logic [3:0] a = '0, b = '0, sum;
    logic       cin = 1'b0, iv = 1'b0, cout, ov, ovf;

    adder_n #(.N(4)) dut (
        .clk(clk), .rst(rst), .SUM(sum), .Cout(cout), .A(a), .B(b),
        .Cin(cin), .in_valid(iv), .out_valid(ov), .ovf(ovf)
    );

    // ---------------- 13-bit slice ----------------
    logic [12:0] wa = '0, wb = '0, wsum;
    logic        wcin = 1'b0, wiv = 1'b0, wcout, wov, wovf;

    adder_n #(.N(13)) dut_w (
        .clk(clk), .rst(rst), .SUM(wsum), .Cout(wcout), .A(wa), .B(wb),
        .Cin(wcin), .in_valid(wiv), .out_valid(wov), .ovf(wovf)
    );

    // ---------------- 8-bit cascade of two 4-bit slices ----------------
    logic [7:0] ca = '0, cb = '0;
    logic       cv = 1'b0;
    logic [3:0] lo_sum, hi_sum, hi_a = '0, hi_b = '0, lo_sum_d = '0;
    logic       lo_cout, lo_ov, lo_ovf, hi_cout, hi_ov, hi_ovf, hi_v = 1'b0;

    adder_n #(.N(4)) dut_lo (
        .clk(clk), .rst(rst), .SUM(lo_sum), .Cout(lo_cout), .A(ca[3:0]),
        .B(cb[3:0]), .Cin(1'b0), .in_valid(cv), .out_valid(lo_ov), .ovf(lo_ovf)
    );

    adder_n #(.N(4)) dut_hi (
        .clk(clk), .rst(rst), .SUM(hi_sum), .Cout(hi_cout), .A(hi_a),
        .B(hi_b), .Cin(lo_cout), .in_valid(hi_v), .out_valid(hi_ov), .ovf(hi_ovf)
    );

    // Alignment: high operands wait one cycle for the low carry, and the
    // low sum waits one cycle for the high result.
    always @(posedge clk) begin
        hi_a     <= ca[7:4];
        hi_b     <= cb[7:4];
        hi_v     <= cv;
        lo_sum_d <= lo_sum;
    end

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer addition; overflow when both operands share
    // a sign and the result sign differs. Returns {ovf, cout, sum[63:0]}.
    function automatic logic [65:0] model(input longint unsigned x, input longint unsigned y,
                                          input bit ci, input int w);
        longint unsigned full, mask, s;
        logic sx, sy, ss, co;
        mask = (64'd1 << w) - 1;
        full = x + y + longint'(ci);
        s    = full & mask;
        co   = full[w];
        sx   = x[w-1];
        sy   = y[w-1];
        ss   = s[w-1];
        return {(sx == sy) && (ss != sx), co, s};
    endfunction

    // Apply one valid 4-bit operation and check the registered result.
    task automatic step4(input logic [3:0] x, input logic [3:0] y, input logic ci);
        logic [65:0] m;
        a = x; b = y; cin = ci; iv = 1'b1;
        @(posedge clk); #1;
        m = model(64'(x), 64'(y), ci, 4);
        check("sum4",  64'(sum),  64'(m[3:0]));
        check("cout4", 64'(cout), 64'(m[64]));
        check("ovf4",  64'(ovf),  64'(m[65]));
        check("ov4",   64'(ov),   64'd1);
    endtask

    initial begin
        logic [65:0] m;
        logic [12:0] e_sum;
        logic        e_cout, e_ovf;
        logic [15:0] q[$];
        logic [15:0] pr;
        logic [8:0]  exp9, got9;

        // Reset held with live operands: everything stays zero.
        a = 4'hF; b = 4'hF; cin = 1'b1; iv = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_sum",  64'(sum),  64'h0);
        check("rst_cout", 64'(cout), 64'h0);
        check("rst_ov",   64'(ov),   64'h0);
        check("rst_ovf",  64'(ovf),  64'h0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        check("first_sum",  64'(sum),  64'hF);
        check("first_cout", 64'(cout), 64'h1);
        check("first_ov",   64'(ov),   64'h1);
        check("first_ovf",  64'(ovf),  64'h0);

        // Directed carry / overflow cases.
        step4(4'h7, 4'h1, 1'b0);
        check("d71_sum", 64'(sum), 64'h8);
        check("d71_ovf", 64'(ovf), 64'h1);
        step4(4'h8, 4'h8, 1'b0);
        check("d88_sum",  64'(sum),  64'h0);
        check("d88_cout", 64'(cout), 64'h1);
        check("d88_ovf",  64'(ovf),  64'h1);
        step4(4'd10, 4'd3, 1'b0);
        check("d103_sum", 64'(sum), 64'd13);
        step4(4'h0, 4'h0, 1'b0);
        check("zero_sum", 64'(sum), 64'h0);

        // Exhaustive 4-bit sweep.
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                for (int c = 0; c < 2; c++)
                    step4(4'(x), 4'(y), 1'(c));

        // Hold: idle cycles with changing operands leave the result alone.
        step4(4'd5, 4'd6, 1'b0);
        check("hold_first", 64'(sum), 64'd11);
        iv = 1'b0; a = 4'd1; b = 4'd1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("hold_sum",  64'(sum),  64'd11);
            check("hold_cout", 64'(cout), 64'd0);
            check("hold_ov",   64'(ov),   64'd0);
            a = 4'(k + 7);
        end

        // Async reset between edges clears outputs before the next edge.
        step4(4'h9, 4'h9, 1'b1);
        #3 rst = 1'b1;
        #1;
        check("arst_sum",  64'(sum),  64'h0);
        check("arst_cout", 64'(cout), 64'h0);
        check("arst_ov",   64'(ov),   64'h0);
        check("arst_ovf",  64'(ovf),  64'h0);
        #2 rst = 1'b0; iv = 1'b0;
        @(posedge clk); #1;
        check("arst_after_sum", 64'(sum), 64'h0);
        check("arst_after_ov",  64'(ov),  64'h0);

        // Random 13-bit traffic with idle cycles; model tracks held values.
        e_sum = '0; e_cout = 1'b0; e_ovf = 1'b0;
        for (int k = 0; k < 400; k++) begin
            wa = 13'($urandom); wb = 13'($urandom); wcin = 1'($urandom);
            wiv = ($urandom % 4) != 0;
            if (k < 4) begin
                wa = (k[0]) ? 13'h1FFF : 13'h0FFF;
                wb = (k[1]) ? 13'h1FFF : 13'h0001;
                wcin = 1'b1; wiv = 1'b1;
            end
            if (wiv) begin
                m = model(64'(wa), 64'(wb), wcin, 13);
                e_sum = m[12:0]; e_cout = m[64]; e_ovf = m[65];
            end
            @(posedge clk); #1;
            check("w_sum",  64'(wsum),  64'(e_sum));
            check("w_cout", 64'(wcout), 64'(e_cout));
            check("w_ovf",  64'(wovf),  64'(e_ovf));
            check("w_ov",   64'(wov),   64'(wiv));
        end
        wiv = 1'b0;

        // Cascade sweep: all i<=j, result appears two cycles after issue.
        for (int i = 0; i < 256; i++) begin
            for (int j = i; j < 258; j++) begin
                if (j < 256) begin
                    ca = 8'(i); cb = 8'(j); cv = 1'b1;
                    q.push_back({8'(i), 8'(j)});
                end else begin
                    cv = 1'b0;
                end
                @(posedge clk); #1;
                if (hi_ov) begin
                    if (q.size() == 0) begin
                        check("casc_spurious", 64'd1, 64'd0);
                    end else begin
                        pr   = q.pop_front();
                        exp9 = 9'(pr[15:8]) + 9'(pr[7:0]);
                        got9 = {hi_cout, hi_sum, lo_sum_d};
                        check("casc_sum", 64'(got9), 64'(exp9));
                        if (pr == 16'h5AC3)
                            check("casc_5a_c3", 64'(got9), 64'h11D);
                    end
                end
            end
            // Drain so each row's last results are checked before the next row.
            cv = 1'b0;
        end
        check("casc_drained", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adder_n.md
Name: adder_n

Overview:
- Parameterised N-bit ripple-carry adder with carry-in and carry-out.
- Result and carry are registered: one clock of latency, async active-high reset.
- Built as a chain of full-adder cells.
- Cascadable: the Cout of a low slice feeds the Cin of a high slice to build a 2N-bit adder, e.g. two N=4 slices form an 8-bit adder.

Parameters:
- N, default 4, operand/sum width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- SUM  output  N  registered sum bits (A+B+Cin) mod 2^N
- Cout  output  1  registered carry out of the MSB
- A  input  N  operand A, unsigned
- B  input  N  operand B, unsigned
- Cin  input  1  carry in to the LSB
- in_valid  input  1  operands valid this cycle
- out_valid  output  1  SUM/Cout hold a new result
- ovf  output  1  registered signed overflow (A, B as two's complement)

Port order for positional instantiation: clk, rst, SUM, Cout, A, B, Cin, in_valid, out_valid, ovf.

Behaviour:
- Combinational core:
  - Ripple chain of N full adders, with c[0]=Cin.
  - s[i]=A[i]^B[i]^c[i].
  - c[i+1]=A[i]&B[i] | c[i]&(A[i]^B[i]).
  - Cout_next=c[N].
  - ovf_next=c[N]^c[N-1]. For N=1, ovf_next=c[1]^Cin.
- Arithmetic invariant: {Cout_next,SUM_next} == A+B+Cin exactly, as an (N+1)-bit unsigned value, for all operand values. No saturation.
- Register stage:
  - On rising clk with in_valid=1: SUM<=s, Cout<=c[N], ovf<=ovf_next, out_valid<=1.
  - On rising clk with in_valid=0: SUM/Cout/ovf hold their previous values and out_valid<=0.
  - Latency is exactly 1 cycle. Throughput is one result per cycle with no back-pressure; the consumer must take a result in the cycle out_valid=1.
- Reset:
  - rst=1 asynchronously forces SUM=0, Cout=0, ovf=0, out_valid=0 immediately, independent of clk.
  - Outputs stay 0 while rst is held.
  - The first result can be captured on the first rising edge after rst deasserts, if in_valid=1.
  - Reset asserted mid-stream discards the pending result; no partial state survives.
- Boundary conditions:
  - All-ones: A=B=2^N-1 with Cin=1 gives SUM=2^N-1, Cout=1.
  - Zero: A=B=0 with Cin=0 gives SUM=0, Cout=0, ovf=0.
  - Wrap-around is modular, and the carry is reported only on Cout.
- X-safety: an X on an unused input while in_valid=0 must not corrupt the held outputs.
- Cascading:
  - Because Cout is registered, a high slice fed by a low slice's registered Cout must receive its A/B delayed by one cycle.
  - The low-half result must likewise be delayed one cycle to align the two halves.
  - The integrating module is responsible for this alignment; this block does not provide it.
- Implementation structure:
  - Full-adder cell via a generate loop or explicit function.
  - No use of the "+" operator for the core, so the ripple structure is explicit.
- Timing: combinational depth is N full-adder stages; no further pipelining.

Test Plan:
- Reset: rst=1 with A=4'hF, B=4'hF, Cin=1, in_valid=1 -> SUM=0, Cout=0, out_valid=0, ovf=0. Release rst, clock once -> SUM=4'hF, Cout=1, out_valid=1.
- Exhaustive, N=4: all A, B in 0..15 with Cin in {0,1}, in_valid=1 -> one cycle later {Cout,SUM}==A+B+Cin. Example: A=10, B=3, Cin=0 -> SUM=13, Cout=0.
- Carry and overflow, N=4:
  - A=4'h7, B=4'h1, Cin=0 -> SUM=4'h8, Cout=0, ovf=1.
  - A=4'h8, B=4'h8 -> SUM=0, Cout=1, ovf=1.
- Hold: apply A=5, B=6, in_valid=1, then in_valid=0 with A=1, B=1 for 3 cycles -> SUM stays 11, Cout=0, out_valid=1 then 0.
- Cascade, two N=4 slices with high-half alignment delay: A=8'h5A, B=8'hC3 -> combined {Cout,SUM}=9'h11D. Sweep all i<=j in 0..255 -> sum == i+j.
- Async reset mid-stream: assert rst between clock edges while out_valid=1 -> outputs go to 0 before the next edge.
